// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Raster timing generator; raw pixel coordinates plus DE/HSYNC/VSYNC
//            delayed to line up with the colour pipeline output.
// Revision : 1.0  initial release
// ============================================================================
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        i_pix_clk,
    input  logic        i_rst,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_active,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [1:0]  o_ctrl_ch0,
    output logic [1:0]  o_ctrl_ch1,
    output logic [1:0]  o_ctrl_ch2
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > 4096) || (V_TOTAL > 4096)) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
    end
    if (PIPE_DLY > 15) begin : g_bad_dly
        $error("video_timing_gen: PIPE_DLY must be 0..15");
    end

    localparam logic [11:0] C_H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] C_V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] C_H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] C_V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] C_HS_BEG   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] C_HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] C_VS_BEG   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] C_VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0]  C_IDLE     = {1'b0, ~H_POL, ~V_POL};

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [12:0] w_h_ext, w_v_ext;
    logic        w_act, w_hs_on, w_vs_on, w_hsync_raw, w_vsync_raw;
    logic [2:0]  w_raw, w_tail;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == C_H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == C_V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        w_h_ext     = {1'b0, h_cnt_q};
        w_v_ext     = {1'b0, v_cnt_q};
        w_act       = (w_h_ext < C_H_ACT) && (w_v_ext < C_V_ACT);
        w_hs_on     = (w_h_ext >= C_HS_BEG) && (w_h_ext < C_HS_END);
        w_vs_on     = (w_v_ext >= C_VS_BEG) && (w_v_ext < C_VS_END);
        w_hsync_raw = w_hs_on ? H_POL : ~H_POL;
        w_vsync_raw = w_vs_on ? V_POL : ~V_POL;
        w_raw       = {w_act, w_hsync_raw, w_vsync_raw};
    end

    if (PIPE_DLY > 0) begin : g_pipe
        logic [2:0] dly_q [PIPE_DLY];
        logic [2:0] dly_d [PIPE_DLY];

        always_comb begin
            dly_d[0] = w_raw;
            for (int i = 1; i < int'(PIPE_DLY); i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end

        // Reset flushes every stage so no stale DE leaks from an interrupted line.
        always_ff @(posedge i_pix_clk) begin
            if (i_rst) begin
                for (int i = 0; i < int'(PIPE_DLY); i++) begin
                    dly_q[i] <= C_IDLE;
                end
            end else begin
                dly_q <= dly_d;
            end
        end

        assign w_tail = dly_q[PIPE_DLY-1];
    end else begin : g_no_pipe
        assign w_tail = i_rst ? C_IDLE : w_raw;
    end

    assign o_x           = h_cnt_q;
    assign o_y           = v_cnt_q;
    assign o_active      = w_act;
    assign o_line_start  = (h_cnt_q == 12'd0) && !i_rst;
    assign o_frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0) && !i_rst;
    assign o_de          = w_tail[2];
    assign o_hsync       = w_tail[1];
    assign o_vsync       = w_tail[0];
    assign o_ctrl_ch0    = {w_tail[0], w_tail[1]};
    assign o_ctrl_ch1    = 2'b00;
    assign o_ctrl_ch2    = 2'b00;

endmodule
`default_nettype wire
